// File: rtl/mmio_io_ctrl.sv
// Purpose : bridges memory-stage load/store requests onto the two-register IO block
//           (output word at offset 0x0, input word at offset 0x4) with sub-word
//           extract/extend on loads and optional read-modify-write for sub-word stores.
// Latency : loads 2 cycles after accept, word stores / errors 1, sub-word stores 3.
// Backpressure: mem_req is held by the requester until the one-cycle mem_ready pulse;
//           requests are only sampled in IDLE.
// Ports   : clk/rst (sync, active-high); mem_* request/response to the memory stage;
//           io_address/io_wr_H_rd_L/io_datain drive the IO block, io_dataout is its
//           registered read port.
// Option  : define MMIO_SUBWORD_STORE_EN to build the RMW path; without it any byte or
//           half store completes with mem_err and no IO strobe.
module mmio_io_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h1000_0000,
    parameter logic [31:0] IO_MASK = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        io_address,
    output logic        io_wr_H_rd_L,
    output logic [31:0] io_datain,
    input  logic [31:0] io_dataout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
`ifdef MMIO_SUBWORD_STORE_EN
        RMW_WR,
`endif
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_addr;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_io_address;
    logic [31:0] r_io_datain;
`ifdef MMIO_SUBWORD_STORE_EN
    logic [31:0] r_wdata;
    logic [31:0] w_merged;
`endif

    logic        w_hit;
    logic        w_misal;
    logic        w_err;
    logic        w_accept;
    logic        w_do_wstore;
    logic        w_do_read;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;

    // ---------------------------------------------------------------- decode
    assign w_hit   = ((mem_addr & IO_MASK) == IO_BASE);
    assign w_misal = ((mem_size == 2'b01) && mem_addr[0]) ||
                     ((mem_size == 2'b10) && (mem_addr[1:0] != 2'b00));

    always_comb begin
        w_err = (mem_size == 2'b11) || w_misal ||
                mem_addr[3] ||                 // words 0x8 / 0xC are unmapped
                (mem_we && mem_addr[2]);       // input register is read-only
`ifndef MMIO_SUBWORD_STORE_EN
        if (mem_we && (mem_size != 2'b10)) begin
            w_err = 1'b1;
        end
`endif
    end

    // Accept is suppressed during reset so no strobe can escape in the reset cycle.
    assign w_accept    = (r_state == IDLE) && mem_req && w_hit && !rst;
    assign w_do_wstore = w_accept && !w_err && mem_we && (mem_size == 2'b10);
    // Loads and the read half of an RMW both issue a read in the accept cycle.
    assign w_do_read   = w_accept && !w_err && !(mem_we && (mem_size == 2'b10));

    // ---------------------------------------------------------------- load extract
    assign w_shifted = io_dataout >> {r_addr, 3'b000};

    always_comb begin
        w_load_val = w_shifted;
        unique case (r_size)
            2'b00:   w_load_val = {{24{~r_uns & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load_val = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_val = w_shifted;
        endcase
    end

`ifdef MMIO_SUBWORD_STORE_EN
    // Drop the store lane(s) into the freshly read output register.
    always_comb begin
        w_merged = io_dataout;
        if (r_size == 2'b00) begin
            w_merged[{r_addr, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end
`endif

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err || w_do_wstore) begin
                        w_next = RESP;
                    end else begin
                        w_next = RD_WAIT;
                    end
                end
            end
`ifdef MMIO_SUBWORD_STORE_EN
            RD_WAIT: w_next = r_we ? RMW_WR : RD_DONE;
            RMW_WR:  w_next = RESP;
`else
            RD_WAIT: w_next = RD_DONE;
`endif
            RD_DONE: w_next = IDLE;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_io_address <= 1'b0;
            r_io_datain  <= '0;
`ifdef MMIO_SUBWORD_STORE_EN
            r_wdata      <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= mem_addr[1:0];
                r_size  <= mem_size;
                r_we    <= mem_we;
                r_uns   <= mem_unsigned;
                r_err   <= w_err;
                r_rdata <= '0;      // stores and errors return zero data
`ifdef MMIO_SUBWORD_STORE_EN
                r_wdata <= mem_wdata;
`endif
            end
            if (w_do_wstore || w_do_read) begin
                r_io_address <= mem_addr[2];
            end
            if (w_do_wstore) begin
                r_io_datain <= mem_wdata;
            end
            if (r_state == RD_WAIT) begin
                if (!r_we) begin
                    r_rdata <= w_load_val;
                end
`ifdef MMIO_SUBWORD_STORE_EN
                else begin
                    r_io_datain <= w_merged;
                end
`endif
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // IO strobes are driven combinationally in the accept cycle so the IO block
    // acts on the edge that ends it; between accesses the registered copies hold.
    assign io_address = (w_do_wstore || w_do_read) ? mem_addr[2] : r_io_address;
    assign io_datain  = w_do_wstore ? mem_wdata : r_io_datain;
`ifdef MMIO_SUBWORD_STORE_EN
    assign io_wr_H_rd_L = w_do_wstore || (r_state == RMW_WR);
`else
    assign io_wr_H_rd_L = w_do_wstore;
`endif

    assign mem_ready = (r_state == RD_DONE) || (r_state == RESP);
    assign mem_err   = r_err && mem_ready;
    assign mem_rdata = r_rdata;

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Bridges memory-stage load/store requests to the memory-mapped IO register pair: output word at offset 0x0, synchronised input word at offset 0x4.
- Decodes the IO window and sequences the IO block's single-cycle read/write strobes around its registered read port.
- Performs byte/half extraction with sign or zero extension on loads, and read-modify-write for sub-word stores.
- Returns data and completion status to the memory stage. RAM accesses are served by a parallel controller; this block ignores non-IO addresses.

Parameters:
- IO_BASE, 32'h1000_0000, base address of the IO window.
- IO_MASK, 32'hFFFF_FFF0, address bits compared against IO_BASE for a window hit (16-byte window).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_req  in  1  request valid; held stable until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  byte address
- mem_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- mem_unsigned  in  1  zero-extend a sub-word load when 1
- mem_wdata  in  32  store data, right-aligned
- mem_rdata  out  32  load result, valid while mem_ready is high
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  qualifies mem_ready; access faulted, no IO write occurred
- io_address  out  1  0 = output register, 1 = input register (to IO block)
- io_wr_H_rd_L  out  1  1 = write strobe, 0 = read (to IO block)
- io_datain  out  32  write data to IO block
- io_dataout  in  32  registered read data from IO block, valid one cycle after a read is driven

Behaviour:
- Hit condition: (mem_addr & IO_MASK) == IO_BASE. Offset = mem_addr[3:0].
  - Word 0x0 (bytes 0x0–0x3) → io_address = 0.
  - Word 0x4 (bytes 0x4–0x7) → io_address = 1.
  - Word 0x8 or 0xC → unmapped.
- States: IDLE, RD_WAIT, RD_DONE, RMW_WR, RESP.
- IDLE:
  - Accept when mem_req && hit. Register addr, size, we, unsigned, wdata.
  - Requests without a hit are ignored: no ready, state unchanged.
- Error at accept (any one of the following):
  - size = 11.
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Unmapped offset.
  - Store to offset 0x4 (input register is read-only).
  - Action: go to RESP with err = 1; no IO strobe is issued.
- Load:
  - Accept cycle (cycle 0): drive io_address, wr = 0, go to RD_WAIT.
  - Cycle 1: capture io_dataout, shift by addr[1:0] × 8, extend per size and unsigned, go to RD_DONE.
  - Cycle 2: mem_ready = 1 with registered mem_rdata.
  - Latency: 2 cycles from accept.
- Word store:
  - Cycle 0: io_wr_H_rd_L = 1, io_address = 0, io_datain = wdata (the IO block writes at this edge).
  - Cycle 1: mem_ready = 1 via RESP.
- Sub-word store (offset 0x0 only):
  - Cycle 0: issue read.
  - Cycle 1: merge wdata lane(s) into io_dataout at addr[1:0].
  - Cycle 2 (RMW_WR): write strobe with merged word.
  - Cycle 3: mem_ready = 1.
- Output defaults:
  - io_wr_H_rd_L is 1 for exactly one cycle per store and 0 at all other times.
  - io_address and io_datain hold their last values when idle.
- Response:
  - RESP is a single cycle: mem_ready = 1, then return to IDLE. A new request may be accepted in the cycle after mem_ready.
  - mem_rdata is 0 for stores and errors.
  - mem_req is not sampled in any state other than IDLE.
- Reset (rst = 1 at a clock edge):
  - State → IDLE.
  - mem_ready, mem_err, mem_rdata, io_address, io_wr_H_rd_L, io_datain → 0.
- Reset mid-operation: the in-flight access is dropped with no response. A write strobe already issued stays committed; none is issued after reset.

Optional Feature:
- MMIO_SUBWORD_STORE_EN
  - Defined: the RMW path above is built.
  - Undefined: RMW_WR is not built, and any byte/half store is an error (RESP, err = 1, no IO strobe). Sub-word loads are unaffected.

Test Plan:
- Word store 0x1000_0000 ← 0xDEAD_BEEF → one-cycle write strobe, io_address = 0, io_datain = 0xDEAD_BEEF, mem_ready 1 cycle after accept, err = 0.
- Load byte 0x1000_0003, output register = 0x80FF_0000, signed → rdata = 0xFFFF_FF80 two cycles after accept; same access unsigned → 0x0000_0080.
- With MMIO_SUBWORD_STORE_EN: half store 0x1000_0002 ← 0x1234 onto 0xAAAA_BBBB → read, then write 0x1234_BBBB, ready at cycle 3. Without the macro: ready at cycle 1, err = 1, no strobe.
- Word load 0x1000_0004 with input register 0x0000_00A5 → io_address = 1, rdata = 0x0000_00A5. Word store 0x1000_0004 → err = 1, no strobe.
- Errors with no IO strobe and ready at cycle 1: word load 0x1000_0002 (misaligned), word load 0x1000_0008 (unmapped), size = 11. Request to 0x2000_0000 → no mem_ready ever.
- rst asserted during RD_WAIT → no mem_ready, all outputs 0 next cycle. A new load after reset completes normally in 2 cycles.
